fft_peak_detect: RTL and testbench

- Downstream stage of the FFT buffer. Consumes the streamed FFT output bins (real/imag plus bin index) for one frame.
- Computes magnitude-squared per bin and tracks the maximum inside a configurable heart-rate band.
- At end of frame, converts the winning bin to beats-per-minute and presents hr/hr_dv. Pulses frame_done, which the FFT buffer uses as its "post data buffer done" to start the next computation.

---
 rtl/pulseox_fft_pkg.sv | 28 ++
 rtl/fft_mag_sq.sv | 79 +++++++
 rtl/fft_peak_detect.sv | 206 ++++++++++++++++++++
 tb/tb_fft_peak_detect.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulseox_fft_pkg.sv
// Shared constants, FSM state type and helpers for the pulse-oximeter FFT post-processing path.
package pulseox_fft_pkg;

  localparam int unsigned DATA_W         = 22;
  localparam int unsigned BIN_W          = 10;
  localparam int unsigned HR_W           = 10;
  localparam int unsigned FS_HZ          = 100;
  localparam int unsigned FFT_N          = 1024;
  localparam int unsigned BPM_PER_BIN_Q8 = (60 * FS_HZ * 256) / FFT_N;
  localparam int unsigned BIN_LO         = 7;
  localparam int unsigned BIN_HI         = 34;
  localparam int unsigned AVG_DEPTH      = 4;
  localparam int unsigned RECIP_W        = 17;

  typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, CONVERT, DONE} state_e;

  // Q16 reciprocal of the history fill level, used for the rounded running mean.
  function automatic logic [RECIP_W-1:0] recip_q16(input logic [2:0] n);
    case (n)
      3'd1:    recip_q16 = 17'd65536;
      3'd2:    recip_q16 = 17'd32768;
      3'd3:    recip_q16 = 17'd21845;
      3'd4:    recip_q16 = 17'd16384;
      default: recip_q16 = 17'd0;
    endcase
  endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage squared-magnitude pipeline (re^2 + im^2) carrying bin index and last flag alongside.
module fft_mag_sq #(
  parameter int unsigned DATA_W = 22,
  parameter int unsigned BIN_W  = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_i,
  input  logic [BIN_W-1:0]         bin_i,
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  input  logic                     last_i,
  output logic                     valid_o,
  output logic [BIN_W-1:0]         bin_o,
  output logic [2*DATA_W:0]        mag_o,
  output logic                     last_o
);

  localparam int unsigned SQ_W  = 2 * DATA_W;
  localparam int unsigned MAG_W = SQ_W + 1;

  logic signed [SQ_W-1:0] re_ext;
  logic signed [SQ_W-1:0] im_ext;
  logic [SQ_W-1:0]        sq_re_d;
  logic [SQ_W-1:0]        sq_im_d;
  logic [SQ_W-1:0]        sq_re_q;
  logic [SQ_W-1:0]        sq_im_q;
  logic                   s1_valid_q;
  logic                   s1_last_q;
  logic [BIN_W-1:0]       s1_bin_q;
  logic [MAG_W-1:0]       mag_d;
  logic [MAG_W-1:0]       mag_q;
  logic                   valid_q;
  logic                   last_q;
  logic [BIN_W-1:0]       bin_q;

  // Sign-extend before squaring so the full-range square is exact.
  always_comb begin
    re_ext  = SQ_W'(re_i);
    im_ext  = SQ_W'(im_i);
    sq_re_d = SQ_W'(re_ext * re_ext);
    sq_im_d = SQ_W'(im_ext * im_ext);
    mag_d   = MAG_W'(sq_re_q) + MAG_W'(sq_im_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_bin_q   <= '0;
      sq_re_q    <= '0;
      sq_im_q    <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      bin_q      <= '0;
      mag_q      <= '0;
    end else begin
      s1_valid_q <= valid_i;
      s1_last_q  <= valid_i & last_i;
      if (valid_i) begin
        s1_bin_q <= bin_i;
        sq_re_q  <= sq_re_d;
        sq_im_q  <= sq_im_d;
      end
      valid_q <= s1_valid_q;
      last_q  <= s1_last_q;
      if (s1_valid_q) begin
        bin_q <= s1_bin_q;
        mag_q <= mag_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign bin_o   = bin_q;
  assign mag_o   = mag_q;
  assign last_o  = last_q;

endmodule

// File: rtl/fft_peak_detect.sv
// Heart-rate peak search over streamed FFT bins; converts the strongest in-band bin to bpm.
// Optional FFT_PEAK_HR_AVG_EN: report the rounded mean of the last 4 valid results.
module fft_peak_detect
  import pulseox_fft_pkg::*;
#(
  parameter int unsigned DATA_W         = pulseox_fft_pkg::DATA_W,
  parameter int unsigned BIN_W          = pulseox_fft_pkg::BIN_W,
  parameter int unsigned BIN_LO         = pulseox_fft_pkg::BIN_LO,
  parameter int unsigned BIN_HI         = pulseox_fft_pkg::BIN_HI,
  parameter int unsigned BPM_PER_BIN_Q8 = pulseox_fft_pkg::BPM_PER_BIN_Q8,
  parameter int unsigned HR_W           = pulseox_fft_pkg::HR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BIN_W-1:0]         in_bin,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_last,
  output logic [HR_W-1:0]          hr,
  output logic                     hr_dv,
  output logic                     peak_found,
  output logic [BIN_W-1:0]         peak_bin,
  output logic                     frame_done
);

  localparam int unsigned MAG_W  = 2 * DATA_W + 1;
  localparam int unsigned HR_MAX = (1 << HR_W) - 1;

  state_e           state_q;
  logic             in_ready_q;
  logic [HR_W-1:0]  hr_q;
  logic             hr_dv_q;
  logic             peak_found_q;
  logic [BIN_W-1:0] peak_bin_q;
  logic             frame_done_q;

  logic             xfer_c;
  logic             mag_valid;
  logic [BIN_W-1:0] mag_bin;
  logic [MAG_W-1:0] mag;
  logic             mag_last;

  logic [MAG_W-1:0] max_mag_q;
  logic [BIN_W-1:0] max_bin_q;
  logic             upd_c;

  logic [31:0]      prod_c;
  logic [31:0]      bpm_c;
  logic             found_c;
  logic [HR_W-1:0]  hr_inst_c;

  assign xfer_c = in_valid & in_ready_q;

  fft_mag_sq #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W)
  ) u_mag_sq (
    .clk     (clk),
    .reset_n (reset_n),
    .valid_i (xfer_c),
    .bin_i   (in_bin),
    .re_i    (in_re),
    .im_i    (in_im),
    .last_i  (in_last),
    .valid_o (mag_valid),
    .bin_o   (mag_bin),
    .mag_o   (mag),
    .last_o  (mag_last)
  );

  // Strict compare: on equal magnitude the earlier bin keeps the peak.
  assign upd_c = mag_valid && (mag_bin >= BIN_W'(BIN_LO)) && (mag_bin <= BIN_W'(BIN_HI))
                 && (mag > max_mag_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_mag_q <= '0;
      max_bin_q <= '0;
    end else if (state_q == DONE) begin
      max_mag_q <= '0;
      max_bin_q <= '0;
    end else if (upd_c) begin
      max_mag_q <= mag;
      max_bin_q <= mag_bin;
    end
  end

  // bpm = round(bin * bpm_per_bin_q8 / 256), saturated to the output width.
  always_comb begin
    prod_c    = 32'(max_bin_q) * 32'(BPM_PER_BIN_Q8);
    bpm_c     = (prod_c + 32'd128) >> 8;
    found_c   = (max_mag_q != '0);
    hr_inst_c = '0;
    if (found_c) begin
      hr_inst_c = (bpm_c > 32'(HR_MAX)) ? HR_W'(HR_MAX) : HR_W'(bpm_c);
    end
  end

`ifdef FFT_PEAK_HR_AVG_EN
  logic [HR_W-1:0]  hist_q [AVG_DEPTH];
  logic [2:0]       hist_cnt_q;
  logic             avg_pend_q;
  logic             pend_found_q;
  logic [BIN_W-1:0] pend_bin_q;
  logic [HR_W+1:0]  hist_sum_c;
  logic [HR_W-1:0]  hr_avg_c;

  // Empty history slots are held at zero, so summing every slot is safe.
  always_comb begin
    hist_sum_c = '0;
    for (int i = 0; i < int'(AVG_DEPTH); i++) begin
      hist_sum_c = hist_sum_c + (HR_W+2)'(hist_q[i]);
    end
    hr_avg_c = HR_W'((32'(hist_sum_c) * 32'(recip_q16(hist_cnt_q)) + 32'd32768) >> 16);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      hr_q         <= '0;
      hr_dv_q      <= 1'b0;
      peak_found_q <= 1'b0;
      peak_bin_q   <= '0;
      frame_done_q <= 1'b0;
`ifdef FFT_PEAK_HR_AVG_EN
      for (int i = 0; i < int'(AVG_DEPTH); i++) hist_q[i] <= '0;
      hist_cnt_q   <= '0;
      avg_pend_q   <= 1'b0;
      pend_found_q <= 1'b0;
      pend_bin_q   <= '0;
`endif
    end else begin
      hr_dv_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
        ACCUM: begin
          if (xfer_c && in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        DRAIN: begin
          // The last bin leaves the pipeline exactly two cycles after its transfer.
          if (mag_valid && mag_last) state_q <= CONVERT;
        end
        CONVERT: begin
`ifdef FFT_PEAK_HR_AVG_EN
          avg_pend_q   <= 1'b1;
          pend_found_q <= found_c;
          pend_bin_q   <= max_bin_q;
          if (found_c) begin
            for (int i = int'(AVG_DEPTH) - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= hr_inst_c;
            if (hist_cnt_q < 3'(AVG_DEPTH)) hist_cnt_q <= hist_cnt_q + 3'd1;
          end
`else
          hr_q         <= hr_inst_c;
          peak_bin_q   <= max_bin_q;
          peak_found_q <= found_c;
          hr_dv_q      <= 1'b1;
`endif
          state_q <= DONE;
        end
        DONE: begin
`ifdef FFT_PEAK_HR_AVG_EN
          if (avg_pend_q) begin
            avg_pend_q   <= 1'b0;
            hr_q         <= pend_found_q ? hr_avg_c : '0;
            peak_bin_q   <= pend_bin_q;
            peak_found_q <= pend_found_q;
            hr_dv_q      <= 1'b1;
          end else begin
            frame_done_q <= 1'b1;
            state_q      <= ACCUM;
            in_ready_q   <= 1'b1;
          end
`else
          frame_done_q <= 1'b1;
          state_q      <= ACCUM;
          in_ready_q   <= 1'b1;
`endif
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign hr         = hr_q;
  assign hr_dv      = hr_dv_q;
  assign peak_found = peak_found_q;
  assign peak_bin   = peak_bin_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: directed frames queue expected results, a monitor checks them.
module tb_fft_peak_detect;
  import pulseox_fft_pkg::*;

`ifdef FFT_PEAK_HR_AVG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [BIN_W-1:0]         in_bin = '0;
  logic signed [DATA_W-1:0] in_re = '0;
  logic signed [DATA_W-1:0] in_im = '0;
  logic                     in_last = 1'b0;
  logic [HR_W-1:0]          hr;
  logic                     hr_dv;
  logic                     peak_found;
  logic [BIN_W-1:0]         peak_bin;
  logic                     frame_done;

  typedef struct {
    int hr;
    int bin;
    int found;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   hist[$];
  int   cyc = 0;
  int   ncmp = 0;
  int   nfail = 0;
  int   fd_exp = -1;
  int   last_cyc = 0;

  fft_peak_detect dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bin     (in_bin),
    .in_re      (in_re),
    .in_im      (in_im),
    .in_last    (in_last),
    .hr         (hr),
    .hr_dv      (hr_dv),
    .peak_found (peak_found),
    .peak_bin   (peak_bin),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    ncmp++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_q(input int hr_i, input int bin_i, input int found_i, input int c);
    exp_t e;
    e.hr = hr_i; e.bin = bin_i; e.found = found_i; e.cyc = c + LAT;
    q.push_back(e);
  endfunction

  // Expected result from the hand-computed instantaneous bpm; averaged when the option is on.
  function automatic void push_exp(input int hr_i, input int bin_i, input int found_i);
    int h;
    h = hr_i;
`ifdef FFT_PEAK_HR_AVG_EN
    if (found_i != 0) begin
      int s;
      hist.push_front(hr_i);
      if (hist.size() > 4) void'(hist.pop_back());
      s = 0;
      foreach (hist[i]) s += hist[i];
      h = (2 * s + hist.size()) / (2 * hist.size());
    end
`endif
    push_q(h, bin_i, found_i, last_cyc);
  endfunction

  // Monitor: every hr_dv pops one expectation; frame_done must follow one cycle later.
  always @(negedge clk) begin
    if (reset_n) begin
      if (q.size() > 0 && cyc > q[0].cyc) begin
        ncmp++; nfail++;
        $display("FAIL hr_dv_missing: none by cycle %0d, required at cycle %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (hr_dv) begin
        if (q.size() == 0) begin
          ncmp++; nfail++;
          $display("FAIL hr_dv_unexpected: got hr_dv at cycle %0d, required none", cyc);
        end else begin
          mon_e = q.pop_front();
          check("hr", int'(hr), mon_e.hr);
          check("peak_bin", int'(peak_bin), mon_e.bin);
          check("peak_found", int'(peak_found), mon_e.found);
          check("hr_dv_cycle", cyc, mon_e.cyc);
        end
        fd_exp = cyc + 1;
      end
      if (frame_done) begin
        check("frame_done_cycle", cyc, fd_exp);
        fd_exp = -1;
      end else if (fd_exp >= 0 && cyc > fd_exp) begin
        ncmp++; nfail++;
        $display("FAIL frame_done_missing: none at cycle %0d, required at cycle %0d", fd_exp, fd_exp);
        fd_exp = -1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    q.delete();
    hist.delete();
    fd_exp = -1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_hr", int'(hr), 0);
    check("rst_hr_dv", int'(hr_dv), 0);
    check("rst_peak_found", int'(peak_found), 0);
    check("rst_peak_bin", int'(peak_bin), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset_n = 1'b1;
  endtask

  // Present one bin from a negedge and hold it until a transfer edge passes.
  task automatic send(input int b, input int re, input int im, input bit last);
    bit got;
    bit done;
    int c;
    in_valid = 1'b1;
    in_bin   = BIN_W'(b);
    in_re    = DATA_W'(re);
    in_im    = DATA_W'(im);
    in_last  = last;
    done     = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      got = in_ready;
      c   = cyc;
      @(negedge clk);
      if (got) begin
        done = 1'b1;
        if (last) last_cyc = c;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      ncmp++; nfail++;
      $display("FAIL send_timeout: bin %0d not accepted, in_ready stayed %0d", b, in_ready);
    end
  endtask

  task automatic full_frame(input int pb, input int pre, input int side, input int stop_at, input bit gaps);
    for (int b = 0; b < 1024; b++) begin
      if (b == stop_at) break;
      send(b, (b == pb) ? pre : ((b == pb - 1) ? side : 0), 0, b == 1023);
      if (gaps) @(negedge clk);
    end
  endtask

  int pk[4]       = '{17, 17, 20, 20};
  int inst_hr[4]  = '{100, 100, 117, 117};
  int avg_hr[4]   = '{100, 100, 106, 109};

  initial begin
    do_reset();

    full_frame(17, 1000, 0, -1, 1'b0);
    push_exp(100, 17, 1);

    send(17, 500, 500, 1'b0);
    send(20, 500, 500, 1'b1);
    push_exp(100, 17, 1);

    send(3, 2097151, 0, 1'b0);
    send(10, 10, 0, 1'b1);
    push_exp(59, 10, 1);

    send(8, 0, 0, 1'b0);
    send(20, 0, 0, 1'b0);
    send(40, 0, 0, 1'b1);
    push_exp(0, 0, 0);

    send(6, 5000, 0, 1'b0);
    send(7, 1, 0, 1'b1);
    push_exp(41, 7, 1);

    send(35, 5000, 0, 1'b0);
    send(34, 2, 0, 1'b0);
    send(33, 1, 1, 1'b1);
    push_exp(199, 34, 1);

    send(9, 2097151, 2097151, 1'b0);
    send(8, -2097152, -2097152, 1'b1);
    push_exp(47, 8, 1);

    send(25, 0, -3, 1'b1);
    push_exp(146, 25, 1);

    send(12, 100, 0, 1'b0);
    send(12, 200, 0, 1'b1);
    push_exp(70, 12, 1);

    repeat (10) @(negedge clk);
    full_frame(30, 200, 100, 500, 1'b1);
    do_reset();
    full_frame(30, 200, 100, -1, 1'b1);
    push_exp(176, 30, 1);

    repeat (10) @(negedge clk);
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send(pk[f], 300, 0, 1'b1);
`ifdef FFT_PEAK_HR_AVG_EN
      push_q(avg_hr[f], pk[f], 1, last_cyc);
`else
      push_q(inst_hr[f], pk[f], 1, last_cyc);
`endif
    end

    for (int t = 0; t < 50 && (q.size() > 0 || fd_exp >= 0); t++) @(negedge clk);
    if (q.size() > 0 || fd_exp >= 0) begin
      ncmp++; nfail++;
      $display("FAIL drain: %0d results still pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
